bpred_bimodal_table: RTL and testbench

- Parametrised successor to the single 2-bit saturating-counter predictor.
- Holds a table of 2^IDX_W saturating counters, CTR_W bits each, indexed by fetch-PC bits.
- Answers one prediction request per cycle with a registered result, and accepts one resolved-branch update per cycle.
- Sits beside the fetch stage; the update port is driven from execute/branch resolution.

---
 rtl/bpred_pkg.sv | 21 ++
 rtl/bpred_bimodal_table_sat_ctr.sv | 33 +++
 rtl/bpred_bimodal_table.sv | 83 ++++++++
 tb/tb_bpred_bimodal_table.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared constants, types and saturating-counter helpers for the bimodal branch predictor.
package bpred_pkg;

  localparam int unsigned CTR_W_DEF = 2;
  localparam int unsigned IDX_W_DEF = 4;
  localparam int unsigned CTR_MAX   = (1 << CTR_W_DEF) - 1;
  localparam int unsigned TAKEN_THR = 1 << (CTR_W_DEF - 1);

  typedef logic [CTR_W_DEF-1:0] ctr_t;
  typedef logic [IDX_W_DEF-1:0] idx_t;

  // Width-generic: callers zero-extend into 32 bits and pass their own ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/bpred_bimodal_table_sat_ctr.sv
// One CTR_W-bit saturating counter with synchronous active-low reset to CTR_INIT.
module bpred_sat_ctr
  import bpred_pkg::*;
#(
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned CTR_INIT = (1 << CTR_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic             upd_taken,
  output logic [CTR_W-1:0] ctr
);

  localparam logic [31:0] MAX = (32'd1 << CTR_W) - 32'd1;

  logic [CTR_W-1:0] r_ctr;
  logic [CTR_W-1:0] w_next;

  always_comb begin
    w_next = r_ctr;
    if (upd_taken) w_next = CTR_W'(sat_inc(32'(r_ctr), MAX));
    else           w_next = CTR_W'(sat_dec(32'(r_ctr)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_ctr <= CTR_W'(CTR_INIT);
    else if (upd_en) r_ctr <= w_next;
  end

  assign ctr = r_ctr;

endmodule

// File: rtl/bpred_bimodal_table.sv
// Bimodal branch predictor: table of saturating counters indexed by PC bits, registered prediction.
// Optional gshare indexing via macro BPRED_GSHARE_EN (adds an IDX_W-bit global history register).
module bpred_bimodal_table
  import bpred_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned PC_LSB   = 2,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned CTR_INIT = (1 << CTR_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] w_ctr [DEPTH];
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_pc;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_pred_idx;

  assign w_pc_idx    = req_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign w_unused_pc = ^req_pc;

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // Request sees the pre-shift history; the shift lands on the same edge as the update.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_ghr <= '0;
    else if (upd_valid) r_ghr <= IDX_W'({r_ghr, upd_taken});
  end

  assign w_idx = w_pc_idx ^ r_ghr;
`else
  assign w_idx = w_pc_idx;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
    bpred_sat_ctr #(
      .CTR_W   (CTR_W),
      .CTR_INIT(CTR_INIT)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_en   (upd_valid && (upd_idx == IDX_W'(gi))),
      .upd_taken(upd_taken),
      .ctr      (w_ctr[gi])
    );
  end

  // Table read happens before the edge, so a same-index update is not bypassed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      r_pred_valid <= req_valid;
      if (req_valid) begin
        r_pred_taken <= w_ctr[w_idx][CTR_W-1];
        r_pred_idx   <= w_idx;
      end
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_idx   = r_pred_idx;

endmodule

// File: tb/tb_bpred_bimodal_table.sv
// Directed scoreboard bench for bpred_bimodal_table (default parameters, either build).
module tb_bpred_bimodal_table;

  typedef struct {
    logic       v;
    logic       t;
    logic [3:0] i;
    logic       full;
    int         id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [3:0]  pred_idx;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;
  logic [3:0]  ghr_m  = '0;

  always #5 clk = ~clk;

  bpred_bimodal_table #(
    .PC_W    (32),
    .IDX_W   (4),
    .PC_LSB  (2),
    .CTR_W   (2),
    .CTR_INIT(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_idx  (pred_idx),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken)
  );

  // PC whose effective table index is idx; upper and sub-LSB bits are noise.
  function automatic logic [31:0] pc_for(input logic [3:0] idx);
`ifdef BPRED_GSHARE_EN
    return {16'hA5A5, 10'h000, idx ^ ghr_m, 2'b11};
`else
    return {16'hA5A5, 10'h000, idx, 2'b11};
`endif
  endfunction

  task automatic step(input logic rn, input logic rv, input logic [31:0] pc,
                      input logic uv, input logic [3:0] ui, input logic ut,
                      input logic ev, input logic et, input logic [3:0] ei, input logic full);
    exp_t e;
    @(negedge clk);
    rst_n = rn; req_valid = rv; req_pc = pc;
    upd_valid = uv; upd_idx = ui; upd_taken = ut;
    e.v = ev; e.t = et; e.i = ei; e.full = full; e.id = vec_id;
    q.push_back(e);
    vec_id++;
    if (!rn)     ghr_m = '0;
    else if (uv) ghr_m = {ghr_m[2:0], ut};
  endtask

  task automatic upd(input logic [3:0] ui, input logic ut);
    step(1'b1, 1'b0, 32'h0, 1'b1, ui, ut, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic req(input logic [3:0] idx, input logic et);
    step(1'b1, 1'b1, pc_for(idx), 1'b0, 4'h0, 1'b0, 1'b1, et, idx, 1'b0);
  endtask

  // Monitor: one scoreboard entry per cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pred_valid !== e.v) begin
          errors++;
          $display("FAIL vec%0d pred_valid got %b want %b", e.id, pred_valid, e.v);
        end
        if (e.v || e.full) begin
          checks++;
          if (pred_taken !== e.t) begin
            errors++;
            $display("FAIL vec%0d pred_taken got %b want %b", e.id, pred_taken, e.t);
          end
          checks++;
          if (pred_idx !== e.i) begin
            errors++;
            $display("FAIL vec%0d pred_idx got %0d want %0d", e.id, pred_idx, e.i);
          end
        end
      end else if (pred_valid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL unexpected pred_valid got 1 want 0");
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

    // First prediction, then hold while idle
    req(4'd4, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1);

    // Train down to 0, saturate at 0, train back up
    upd(4'd4, 1'b0); upd(4'd4, 1'b0); upd(4'd4, 1'b0);
    req(4'd4, 1'b0);
    upd(4'd4, 1'b0);
    req(4'd4, 1'b0);
    upd(4'd4, 1'b1); upd(4'd4, 1'b1);
    req(4'd4, 1'b1);

    // Saturate at 3, then hysteresis (2 still taken, 1 not taken)
    upd(4'd4, 1'b1); upd(4'd4, 1'b1); upd(4'd4, 1'b1);
    upd(4'd4, 1'b0);
    req(4'd4, 1'b1);
    upd(4'd4, 1'b0);
    req(4'd4, 1'b0);

    // Same-index request and update: read-before-write
    upd(4'd5, 1'b0);
    step(1'b1, 1'b1, pc_for(4'd5), 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    req(4'd5, 1'b0);

    // Different indices in the same cycle are independent
    step(1'b1, 1'b1, pc_for(4'd6), 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
    req(4'd7, 1'b1);

    // Reset overrides concurrent req/upd and restores CTR_INIT
    upd(4'd4, 1'b0);
    step(1'b0, 1'b1, pc_for(4'd4), 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    req(4'd4, 1'b1);

    // Reset mid-stream drops the in-flight prediction
    req(4'd4, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

    // History: two taken updates, then raw pc 0x10
    upd(4'd0, 1'b1); upd(4'd0, 1'b1);
`ifdef BPRED_GSHARE_EN
    step(1'b1, 1'b1, 32'h10, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
`else
    step(1'b1, 1'b1, 32'h10, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
`endif
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
